turn_scheduler: RTL
===================

// Module: turn_scheduler
// PURPOSE
//  Game-level turn arbiter for cat-vs-dog: grants the aim/throw right to exactly one side at a time
//  via cat_turn/dog_turn (which gate each side's throw FSM), detects that side's throw, tracks the
//  projectile flight to landing, applies damage and alternates turns until a side reaches 0 HP.
//  Sits between the per-side throw FSMs, the projectile engine and the HUD/score renderer.
// PARAMETERS
//  CLK_HZ        65_000_000  system clock frequency (Hz)
//  TURN_TIME_S   10          aim window per turn in seconds (used only with TURN_TIMEOUT_EN)
//  SETTLE_CYC    CLK_HZ/2    pause between landing and next turn, cycles (>=1)
//  HP_INIT       8'd100      starting hit points per side
//  HIT_DMG       8'd20       damage per hit
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  start        in   1  level; begins/restarts a game (sampled in IDLE and OVER)
//  cat_throw    in   1  cat throw FSM throw_enable (level)
//  dog_throw    in   1  dog throw FSM throw_enable (level)
//  proj_done    in   1  1-cycle pulse: projectile has landed or left screen
//  proj_hit     in   1  qualifies proj_done: 1 = opponent hit
//  cat_turn     out  1  cat may aim/throw
//  dog_turn     out  1  dog may aim/throw
//  launch       out  1  1-cycle pulse: start projectile engine
//  launch_side  out  1  0 = cat, 1 = dog; valid with launch, held until next launch
//  in_flight    out  1  projectile in the air
//  cat_hp       out  8  cat hit points
//  dog_hp       out  8  dog hit points
//  turn_cnt     out  8  completed turns, wraps 255->0
//  game_over    out  1  game ended
//  winner       out  1  0 = cat, 1 = dog; valid while game_over
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; all 1-bit outputs 0; turn_cnt 0; hp = HP_INIT.
//  All outputs are registered. cat_turn/dog_turn are one-hot or both 0 and never both 1.
//  States: IDLE, CAT_AIM, CAT_FLIGHT, DOG_AIM, DOG_FLIGHT, SETTLE, OVER.
//  IDLE: start=1 -> CAT_AIM (hp reloaded to HP_INIT, turn_cnt 0); cat always opens.
//  X_AIM: X_turn=1. Rising edge of the active side's throw (registered prev) -> launch=1 next cycle,
//   launch_side set, X_turn->0, in_flight->1, -> X_FLIGHT. The inactive side's throw is ignored.
//  X_FLIGHT: wait for proj_done; there is no flight timeout. On proj_done&proj_hit the opponent's
//   hp is reduced by HIT_DMG, saturating at 0. in_flight->0, turn_cnt+1.
//   If the resulting hp is 0 -> OVER, winner = X. Otherwise -> SETTLE.
//  SETTLE: count SETTLE_CYC cycles, then go to the opposite side's AIM.
//  OVER: game_over=1, no turns granted; start=1 -> reinit as in IDLE -> CAT_AIM.
//  proj_done outside FLIGHT is ignored. A throw edge already high on AIM entry does not launch;
//   a fresh rising edge is required.
//  start while a game is running is ignored. Reset mid-game aborts immediately with no pulse glitch.
// CONFIGURATION
//  TURN_TIMEOUT_EN defined: an aim timer (TURN_TIME_S*CLK_HZ cycles, reloaded on AIM entry) runs
//   in X_AIM. Expiry forfeits the turn: no launch, turn_cnt+1, -> SETTLE. A throw edge arriving in
//   the same cycle as expiry wins and launches.
//  TURN_TIMEOUT_EN undefined: no timer logic; AIM waits indefinitely.
// STRUCTURE
//  game_pkg: typedef enum sched_state_t; typedef enum logic {SIDE_CAT, SIDE_DOG} side_t;
//   HP_W=8 localparam. Package shared with the throw FSMs and the HUD.
//  Sub-module cycle_timer (load, count, expired): reused by SETTLE and the optional aim timeout.
// TESTING (CLK_HZ=100, SETTLE_CYC=4, TURN_TIME_S=1, HP_INIT=40, HIT_DMG=20)
//  Reset then start=1 -> next cycle cat_turn=1, dog_turn=0, cat_hp=dog_hp=40, game_over=0.
//  cat_throw 0->1 in CAT_AIM -> launch=1 for exactly 1 cycle, launch_side=0, cat_turn=0, in_flight=1.
//  proj_done+proj_hit -> dog_hp=20, turn_cnt=1; dog_turn=1 exactly 4 cycles later.
//  dog_throw pulsed during CAT_AIM/CAT_FLIGHT -> no launch; stray proj_done in AIM -> hp unchanged.
//  Two cat hits (HP 40->20->0) -> game_over=1, winner=0, no further turns; start -> hp=40, CAT_AIM.
//  TURN_TIMEOUT_EN: no throw for 100 cycles -> turn forfeited, no launch, turn_cnt+1, then dog_turn.
//  Deassert rst_n during DOG_FLIGHT -> all outputs 0 and hp=40 asynchronously.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: types and widths shared by the turn scheduler, the per-side throw
// FSMs and the HUD/score renderer.
//   sched_state_t : turn scheduler states
//   side_t        : which side is meant (cat = 0, dog = 1)
//   score_t       : hit points of both sides plus the completed-turn counter
//   hp_sub_sat    : hit-point subtraction that stops at zero
package game_pkg;

  localparam int unsigned HP_W   = 8;
  localparam int unsigned TURN_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAT_AIM,
    ST_CAT_FLIGHT,
    ST_DOG_AIM,
    ST_DOG_FLIGHT,
    ST_SETTLE,
    ST_OVER
  } sched_state_t;

  typedef enum logic {
    SIDE_CAT = 1'b0,
    SIDE_DOG = 1'b1
  } side_t;

  typedef struct packed {
    logic [HP_W-1:0]   cat_hp;
    logic [HP_W-1:0]   dog_hp;
    logic [TURN_W-1:0] turn_cnt;
  } score_t;

  // Damage never wraps a side below zero hit points.
  function automatic logic [HP_W-1:0] hp_sub_sat(input logic [HP_W-1:0] hp,
                                                 input logic [HP_W-1:0] dmg);
    return (hp > dmg) ? HP_W'(hp - dmg) : '0;
  endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// turn_scheduler_if: game-level signals between the turn scheduler (slave)
// and its environment (master: throw FSMs, projectile engine, HUD).
//   master drives : start, cat_throw, dog_throw, proj_done, proj_hit
//   slave drives  : cat_turn, dog_turn, launch, launch_side, in_flight,
//                   cat_hp, dog_hp, turn_cnt, game_over, winner
interface turn_scheduler_if;
  import game_pkg::*;

  logic              start;
  logic              cat_throw;
  logic              dog_throw;
  logic              proj_done;
  logic              proj_hit;
  logic              cat_turn;
  logic              dog_turn;
  logic              launch;
  side_t             launch_side;
  logic              in_flight;
  logic [HP_W-1:0]   cat_hp;
  logic [HP_W-1:0]   dog_hp;
  logic [TURN_W-1:0] turn_cnt;
  logic              game_over;
  side_t             winner;

  modport master (
    output start, cat_throw, dog_throw, proj_done, proj_hit,
    input  cat_turn, dog_turn, launch, launch_side, in_flight,
           cat_hp, dog_hp, turn_cnt, game_over, winner
  );

  modport slave (
    input  start, cat_throw, dog_throw, proj_done, proj_hit,
    output cat_turn, dog_turn, launch, launch_side, in_flight,
           cat_hp, dog_hp, turn_cnt, game_over, winner
  );

endinterface

// File: rtl/turn_scheduler_cycle_timer.sv
// cycle_timer: loadable down-counter used for the settle pause and the
// optional aim timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (wins over count)
//   load_val   : cycles to wait minus one
//   count      : decrement while nonzero
//   expired_c  : combinational, high while counting and the count is zero
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         expired_c
);

  logic [W-1:0] cnt_q;

  // Down-counter; holds at zero until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_c = count && (cnt_q == '0);

endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: cat-vs-dog turn arbiter. Grants the aim/throw right to one
// side at a time, launches the projectile on a fresh throw edge, waits for
// the landing, applies damage, pauses, then hands the turn to the other side
// until one side reaches 0 HP.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : turn_scheduler_if.slave (start, throws, projectile status in;
//                turns, launch, in_flight, hit points, turn_cnt, game_over,
//                winner out; every output is a flop)
// Build option: define TURN_TIMEOUT_EN to add an aim timeout of
// TURN_TIME_S*CLK_HZ cycles that forfeits an idle turn.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int unsigned     CLK_HZ      = 65_000_000,
  parameter int unsigned     TURN_TIME_S = 10,
  parameter int unsigned     SETTLE_CYC  = CLK_HZ / 2,
  parameter logic [HP_W-1:0] HP_INIT     = 8'd100,
  parameter logic [HP_W-1:0] HIT_DMG     = 8'd20
) (
  input  logic             clk,
  input  logic             rst_n,
  turn_scheduler_if.slave  bus
);

  // One counter serves both delays, so it is sized for the longer one.
  localparam int unsigned AIM_CYC = TURN_TIME_S * CLK_HZ;
  localparam int unsigned MAX_CYC = (AIM_CYC > SETTLE_CYC) ? AIM_CYC : SETTLE_CYC;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC) + 1;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] AIM_LOAD    = TMR_W'(AIM_CYC - 1);

  sched_state_t state_q, state_d;
  logic         cat_turn_q, cat_turn_d;
  logic         dog_turn_q, dog_turn_d;
  logic         launch_q, launch_d;
  side_t        launch_side_q, launch_side_d;
  logic         in_flight_q, in_flight_d;
  score_t       score_q, score_d;
  logic         game_over_q, game_over_d;
  side_t        winner_q, winner_d;
  side_t        next_side_q, next_side_d;
  logic         cat_throw_q, dog_throw_q;

  logic             cat_rise_c, dog_rise_c, rise_c;
  side_t            act_side_c, opp_side_c;
  logic [HP_W-1:0]  opp_hp_c;
  logic             tmr_load_c, tmr_count_c, tmr_expired_c;
  logic [TMR_W-1:0] tmr_val_c;

  assign cat_rise_c = bus.cat_throw & ~cat_throw_q;
  assign dog_rise_c = bus.dog_throw & ~dog_throw_q;

  cycle_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (tmr_load_c),
    .load_val  (tmr_val_c),
    .count     (tmr_count_c),
    .expired_c (tmr_expired_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d       = state_q;
    cat_turn_d    = cat_turn_q;
    dog_turn_d    = dog_turn_q;
    launch_d      = 1'b0;
    launch_side_d = launch_side_q;
    in_flight_d   = in_flight_q;
    score_d       = score_q;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    next_side_d   = next_side_q;
    tmr_load_c    = 1'b0;
    tmr_val_c     = '0;
    tmr_count_c   = 1'b0;

    act_side_c = ((state_q == ST_DOG_AIM) || (state_q == ST_DOG_FLIGHT)) ? SIDE_DOG : SIDE_CAT;
    opp_side_c = (act_side_c == SIDE_DOG) ? SIDE_CAT : SIDE_DOG;
    rise_c     = (act_side_c == SIDE_DOG) ? dog_rise_c : cat_rise_c;
    // Opponent hit points after this landing.
    opp_hp_c   = (act_side_c == SIDE_DOG) ? score_q.cat_hp : score_q.dog_hp;
    if (bus.proj_hit) begin
      opp_hp_c = hp_sub_sat(opp_hp_c, HIT_DMG);
    end

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d          = ST_CAT_AIM;
          cat_turn_d       = 1'b1;
          dog_turn_d       = 1'b0;
          score_d.cat_hp   = HP_INIT;
          score_d.dog_hp   = HP_INIT;
          score_d.turn_cnt = '0;
          game_over_d      = 1'b0;
          winner_d         = SIDE_CAT;
          tmr_load_c       = 1'b1;
          tmr_val_c        = AIM_LOAD;
        end
      end

      ST_CAT_AIM, ST_DOG_AIM: begin
`ifdef TURN_TIMEOUT_EN
        tmr_count_c = 1'b1;
`endif
        // A throw edge in the expiry cycle still launches.
        if (rise_c) begin
          launch_d      = 1'b1;
          launch_side_d = act_side_c;
          cat_turn_d    = 1'b0;
          dog_turn_d    = 1'b0;
          in_flight_d   = 1'b1;
          state_d       = (act_side_c == SIDE_DOG) ? ST_DOG_FLIGHT : ST_CAT_FLIGHT;
        end
`ifdef TURN_TIMEOUT_EN
        else if (tmr_expired_c) begin
          cat_turn_d       = 1'b0;
          dog_turn_d       = 1'b0;
          score_d.turn_cnt = score_q.turn_cnt + TURN_W'(1);
          next_side_d      = opp_side_c;
          state_d          = ST_SETTLE;
          tmr_load_c       = 1'b1;
          tmr_val_c        = SETTLE_LOAD;
        end
`endif
      end

      ST_CAT_FLIGHT, ST_DOG_FLIGHT: begin
        if (bus.proj_done) begin
          in_flight_d      = 1'b0;
          score_d.turn_cnt = score_q.turn_cnt + TURN_W'(1);
          if (act_side_c == SIDE_DOG) begin
            score_d.cat_hp = opp_hp_c;
          end else begin
            score_d.dog_hp = opp_hp_c;
          end
          if (opp_hp_c == '0) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
            winner_d    = act_side_c;
          end else begin
            state_d     = ST_SETTLE;
            next_side_d = opp_side_c;
            tmr_load_c  = 1'b1;
            tmr_val_c   = SETTLE_LOAD;
          end
        end
      end

      ST_SETTLE: begin
        tmr_count_c = 1'b1;
        if (tmr_expired_c) begin
          if (next_side_q == SIDE_DOG) begin
            state_d    = ST_DOG_AIM;
            dog_turn_d = 1'b1;
          end else begin
            state_d    = ST_CAT_AIM;
            cat_turn_d = 1'b1;
          end
          tmr_load_c = 1'b1;
          tmr_val_c  = AIM_LOAD;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        cat_turn_d = 1'b0;
        dog_turn_d = 1'b0;
      end
    endcase
  end

  // State, output and throw-history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cat_turn_q       <= 1'b0;
      dog_turn_q       <= 1'b0;
      launch_q         <= 1'b0;
      launch_side_q    <= SIDE_CAT;
      in_flight_q      <= 1'b0;
      score_q.cat_hp   <= HP_INIT;
      score_q.dog_hp   <= HP_INIT;
      score_q.turn_cnt <= '0;
      game_over_q      <= 1'b0;
      winner_q         <= SIDE_CAT;
      next_side_q      <= SIDE_CAT;
      cat_throw_q      <= 1'b0;
      dog_throw_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cat_turn_q    <= cat_turn_d;
      dog_turn_q    <= dog_turn_d;
      launch_q      <= launch_d;
      launch_side_q <= launch_side_d;
      in_flight_q   <= in_flight_d;
      score_q       <= score_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      next_side_q   <= next_side_d;
      cat_throw_q   <= bus.cat_throw;
      dog_throw_q   <= bus.dog_throw;
    end
  end

  assign bus.cat_turn    = cat_turn_q;
  assign bus.dog_turn    = dog_turn_q;
  assign bus.launch      = launch_q;
  assign bus.launch_side = launch_side_q;
  assign bus.in_flight   = in_flight_q;
  assign bus.cat_hp      = score_q.cat_hp;
  assign bus.dog_hp      = score_q.dog_hp;
  assign bus.turn_cnt    = score_q.turn_cnt;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule
